mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single off-chip memory port between the I-cache refill path (read-only) and the D-cache refill/write-back path of the pipelined CPU.
- Sits between the two cache controllers and the slow main memory.
- Arbitrates requests, holds one transaction open until memory acknowledges, and returns data and ready to the winning requester.

Parameters:
- ADDR_W, 28, line-address width (32-bit byte address minus 4 offset bits, 16-byte line).
- DATA_W, 128, line width in bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_read  in  1  I-cache line read request (level, held until i_ready).
- i_addr  in  ADDR_W  I-cache line address.
- i_rdata  out  DATA_W  line data to I-cache.
- i_ready  out  1  one-cycle completion pulse to I-cache.
- d_read  in  1  D-cache line read request (level).
- d_write  in  1  D-cache line write-back request (level).
- d_addr  in  ADDR_W  D-cache line address.
- d_wdata  in  DATA_W  write-back data.
- d_rdata  out  DATA_W  line data to D-cache.
- d_ready  out  1  one-cycle completion pulse to D-cache.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory line address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid while mem_ready=1.
- mem_ready  in  1  memory one-cycle completion pulse.

Behaviour:
- Reset values:
  - Outputs: mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, i_ready=0, d_ready=0.
  - State: FSM=IDLE, last_grant=I, so D wins the first tie.
- FSM states IDLE, BUSY_I, BUSY_D.
- IDLE:
  - Sample requests each cycle.
  - Only I pending -> BUSY_I.
  - Only D pending -> BUSY_D.
  - Both pending -> grant the requester not equal to last_grant (round-robin).
  - On grant: register address (and d_wdata, plus write flag for D) into the mem_* output registers; update last_grant.
  - mem_read/mem_write rise the cycle after the request is first seen in IDLE (1-cycle arbitration latency).
- BUSY_I:
  - mem_read=1 and mem_addr stable until mem_ready.
  - On mem_ready: i_ready=1 and i_rdata=mem_rdata in the same cycle (combinational pass-through).
  - Registered strobes clear; next state IDLE.
- BUSY_D:
  - Same as BUSY_I, with mem_write=1 for write-back or mem_read=1 for refill.
  - d_ready pulses on mem_ready; d_rdata=mem_rdata (don't-care for writes).
- i_rdata/d_rdata carry mem_rdata continuously; they are meaningful only with the matching ready.
- Requester contract: keep req and addr/wdata stable until ready; drop or change req in the cycle after ready. The arbiter re-arbitrates in that IDLE cycle, so a held request is served again.
- d_read and d_write both high is illegal: d_write takes precedence, and a simulation-only assertion fires.
- Requests arriving during BUSY_* wait; no preemption and no queueing beyond the level request.
- mem_ready while IDLE is ignored: no ready pulse is generated and an assertion fires.
- Reset mid-transaction: FSM returns to IDLE next edge and strobes drop. The outstanding access is abandoned; memory is reset with the same rst.
- Max throughput: one transaction per (memory latency + 1) cycles. No starvation: a waiting requester is served at most one transaction after the current one.

Optional Feature:
- Macro MEM_ARBITER_PERF_CNT_EN.
- When defined:
  - Adds outputs i_wait_cnt and d_wait_cnt (32-bit each).
  - Each counts cycles its request is asserted but not granted (IDLE-loss or other side BUSY).
  - Saturating at 32'hFFFFFFFF; cleared by rst.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package mem_arbiter_pkg:
  - State encoding localparams (IDLE=2'd0, BUSY_I=2'd1, BUSY_D=2'd2).
  - Grant-ID constants (GNT_I=1'b0, GNT_D=1'b1).
  - Default ADDR_W/DATA_W.
- One sub-module, sat_counter (32-bit saturating enable counter), instantiated twice under the macro. All else is flat.

Test Plan:
- I-only: i_read=1, i_addr=28'h0000010, memory latency 3:
  - mem_read=1 from cycle 1; mem_addr=28'h0000010.
  - i_ready pulse in cycle 4 with i_rdata=mem_rdata; d_ready stays 0.
- D write-back: d_write=1, d_addr=28'h0000ABC, d_wdata=128'hDEAD...BEEF:
  - mem_write=1 with matching addr/wdata until mem_ready; d_ready pulse once; mem_read stays 0.
- Simultaneous: i_read and d_read rise in the same cycle after reset:
  - D served first, then I; exactly one ready pulse each.
- Fairness: D holds d_read across three transactions while i_read stays asserted:
  - Grant order D, I, D; I waits at most one transaction.
- Reset mid-transaction: assert rst during BUSY_D before mem_ready:
  - Next edge: mem_read=mem_write=0, no d_ready, FSM IDLE.
  - A new i_read is then granted normally.
- With MEM_ARBITER_PERF_CNT_EN: I blocked for 5 cycles behind a D transaction:
  - i_wait_cnt=5 and d_wait_cnt=0 afterwards.
  - Preload near max to verify saturation at 32'hFFFFFFFF.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state encoding, grant IDs and default widths for mem_arbiter
package mem_arbiter_pkg;
    localparam int DEF_ADDR_W = 28;
    localparam int DEF_DATA_W = 128;
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2} state_t;
    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;
endpackage

// File: rtl/mem_arbiter_sat_counter.sv
// sat_counter: 32-bit enable counter that sticks at all-ones until reset
module sat_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [31:0] cnt
);
    // count enabled cycles, holding at the ceiling
    always_ff @(posedge clk)
        if (rst) cnt <= '0;
        else if (en && cnt != '1) cnt <= cnt + 32'd1;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one memory port between I-cache and D-cache refill/write-back
// Optional MEM_ARBITER_PERF_CNT_EN adds saturating per-requester wait-cycle counters.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
`ifdef MEM_ARBITER_PERF_CNT_EN
    ,
    output logic [31:0]       i_wait_cnt,
    output logic [31:0]       d_wait_cnt
`endif
);
    state_t state;
    logic   last_grant;
    logic   d_req;
    logic   pick_d;

    assign d_req   = d_read | d_write;
    assign pick_d  = d_req & (~i_read | (last_grant == GNT_I));
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;
    assign i_ready = (state == BUSY_I) & mem_ready;
    assign d_ready = (state == BUSY_D) & mem_ready;

    // arbitrate in IDLE, then hold the registered memory request until memory completes
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GNT_I;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else if (state == IDLE) begin
            if (i_read | d_req) begin
                state      <= pick_d ? BUSY_D : BUSY_I;
                last_grant <= pick_d ? GNT_D : GNT_I;
                mem_addr   <= pick_d ? d_addr : i_addr;
                mem_wdata  <= pick_d ? d_wdata : mem_wdata;
                mem_write  <= pick_d & d_write;
                mem_read   <= ~(pick_d & d_write);
            end
        end else if (mem_ready) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end
    end

`ifdef MEM_ARBITER_PERF_CNT_EN
    sat_counter u_i_wait (
        .clk (clk),
        .rst (rst),
        .en  (i_read & (((state == IDLE) & pick_d) | (state == BUSY_D))),
        .cnt (i_wait_cnt)
    );
    sat_counter u_d_wait (
        .clk (clk),
        .rst (rst),
        .en  (d_req & (((state == IDLE) & ~pick_d) | (state == BUSY_I))),
        .cnt (d_wait_cnt)
    );
`endif

`ifndef SYNTHESIS
    a_no_rw_both: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write));
    a_no_idle_ready: assert property (@(posedge clk) disable iff (rst) !(state == IDLE && mem_ready));
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_mem_arbiter;
    localparam int AW = 28;
    localparam int DW = 128;
    localparam logic [DW-1:0] WB_DATA = 128'hDEAD_0001_0002_0003_0004_0005_0006_BEEF;

    logic          clk = 1'b0, rst = 1'b1;
    logic          i_read = 1'b0, d_read = 1'b0, d_write = 1'b0, mem_ready = 1'b0;
    logic [AW-1:0] i_addr = '0, d_addr = '0;
    logic [DW-1:0] d_wdata = '0, mem_rdata = '0;
    logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic          i_ready, d_ready, mem_read, mem_write;
`ifdef MEM_ARBITER_PERF_CNT_EN
    logic [31:0]   i_wait_cnt, d_wait_cnt;
`endif

    int checks = 0, errors = 0;
    int lat = 3;
    bit rand_lat = 1'b0;
    int mcnt = 0;
    logic [DW-1:0] store [logic [AW-1:0]];
    int log_q[$];

    mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .i_read    (i_read),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_ready   (i_ready),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
`ifdef MEM_ARBITER_PERF_CNT_EN
        ,
        .i_wait_cnt (i_wait_cnt),
        .d_wait_cnt (d_wait_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_content(input logic [AW-1:0] a);
        return store.exists(a) ? store[a] : {a, 4'h1, a, 4'h2, a, 4'h3, a, 4'h4};
    endfunction

    // memory: answers lat cycles after the first strobe cycle with a one-cycle ready pulse
    always @(posedge clk) begin
        #1;
        if (rst) begin
            mem_ready = 1'b0;
            mcnt = 0;
        end else if (mem_ready) begin
            mem_ready = 1'b0;
            mcnt = 0;
            mem_rdata = {4{$urandom}};
        end else if (mem_read || mem_write) begin
            if (mcnt >= lat) begin
                mem_ready = 1'b1;
                if (mem_write) store[mem_addr] = mem_wdata;
                mem_rdata = mem_write ? {4{$urandom}} : mem_content(mem_addr);
                if (rand_lat) lat = $urandom_range(1, 4);
            end else mcnt++;
        end
    end

    // completion order log: 0 = I, 1 = D
    always @(negedge clk)
        if (!rst) begin
            if (i_ready) log_q.push_back(0);
            if (d_ready) log_q.push_back(1);
        end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        log_q.delete();
    endtask

    task automatic wait_ready(input bit d, output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!(d ? d_ready : i_ready) && n < 50);
        if (!(d ? d_ready : i_ready)) n = -1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; i_read = 1'b1; i_addr = 28'h123;
        repeat (3) @(negedge clk);
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read: got %b want 0", mem_read); end
        checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write: got %b want 0", mem_write); end
        checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        checks++; if (mem_wdata !== '0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL reset_i_ready: got %b want 0", i_ready); end
        checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL reset_d_ready: got %b want 0", d_ready); end
        i_read = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_i_only();
        int bad = 0;
        lat = 3;
        i_addr = 28'h0000010; i_read = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 28'h0000010) begin
            errors++; $display("FAIL i_only_grant: got rd=%b wr=%b addr=%h want rd=1 wr=0 addr=0000010", mem_read, mem_write, mem_addr);
        end
        repeat (2) begin
            @(negedge clk);
            if (mem_read !== 1'b1 || mem_addr !== 28'h0000010 || i_ready !== 1'b0 || d_ready !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL i_only_hold: got %0d bad cycles want 0", bad); end
        @(negedge clk);
        checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL i_only_ready_cycle4: got %b want 1", i_ready); end
        checks++; if (i_rdata !== mem_content(28'h0000010)) begin errors++; $display("FAIL i_only_rdata: got %h want %h", i_rdata, mem_content(28'h0000010)); end
        checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL i_only_d_ready: got %b want 0", d_ready); end
        i_read = 1'b0;
        @(negedge clk);
        checks++; if (mem_read !== 1'b0 || i_ready !== 1'b0) begin errors++; $display("FAIL i_only_release: got rd=%b rdy=%b want 0 0", mem_read, i_ready); end
        @(negedge clk);
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL i_only_no_regrant: got %b want 0", mem_read); end
    endtask

    task automatic test_d_write();
        int n = 0, bad = 0;
        lat = 2;
        d_addr = 28'h0000ABC; d_wdata = WB_DATA; d_write = 1'b1;
        do begin
            @(negedge clk); n++;
            if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 28'h0000ABC || mem_wdata !== WB_DATA || i_ready !== 1'b0) bad++;
        end while (!d_ready && n < 20);
        checks++; if (d_ready !== 1'b1 || n != 3) begin errors++; $display("FAIL dwr_ready: got rdy=%b at cycle %0d want 1 at 3", d_ready, n); end
        checks++; if (bad != 0) begin errors++; $display("FAIL dwr_strobe: got %0d bad cycles want 0", bad); end
        d_write = 1'b0;
        @(negedge clk);
        checks++; if (mem_write !== 1'b0 || d_ready !== 1'b0) begin errors++; $display("FAIL dwr_single_pulse: got wr=%b rdy=%b want 0 0", mem_write, d_ready); end
        d_read = 1'b1;
        wait_ready(1'b1, n);
        checks++; if (n != 3) begin errors++; $display("FAIL dwr_readback_latency: got %0d want 3", n); end
        checks++; if (d_rdata !== WB_DATA) begin errors++; $display("FAIL dwr_readback_data: got %h want %h", d_rdata, WB_DATA); end
        d_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_simultaneous();
        int n = 0;
        do_reset();
        lat = 2;
        i_addr = 28'h20; d_addr = 28'h30; i_read = 1'b1; d_read = 1'b1;
        @(negedge clk);
        checks++; if (mem_read !== 1'b1 || mem_addr !== 28'h30) begin errors++; $display("FAIL sim_first_grant: got rd=%b addr=%h want 1 030", mem_read, mem_addr); end
        do begin
            if (d_ready) d_read = 1'b0;
            if (i_ready) i_read = 1'b0;
            if (d_read || i_read) begin @(negedge clk); n++; end
        end while ((d_read || i_read) && n < 40);
        repeat (3) @(negedge clk);
        checks++; if (log_q.size() != 2) begin errors++; $display("FAIL sim_count: got %0d ready pulses want 2", log_q.size()); end
        checks++; if (log_q.size() < 2 || log_q[0] != 1 || log_q[1] != 0) begin errors++; $display("FAIL sim_order: got %p want D then I", log_q); end
    endtask

    task automatic test_fairness();
        int dc = 0, ic = 0, n = 0, bad = 0;
        int exp_seq[6] = '{1, 0, 1, 0, 1, 0};
        do_reset();
        lat = 2;
        d_addr = 28'h200; i_addr = 28'h100; d_read = 1'b1; i_read = 1'b1;
        do begin
            @(negedge clk); n++;
            if (d_ready) begin dc++; if (dc == 3) d_read = 1'b0; end
            if (i_ready) begin ic++; if (ic == 3) i_read = 1'b0; end
        end while ((d_read || i_read) && n < 200);
        @(negedge clk);
        checks++; if (log_q.size() != 6) begin errors++; $display("FAIL fair_count: got %0d want 6", log_q.size()); end
        for (int i = 0; i < 6 && i < log_q.size(); i++) if (log_q[i] != exp_seq[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL fair_order: got %p want D I D I D I", log_q); end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        lat = 5;
        d_addr = 28'h40; d_read = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (mem_read !== 1'b1 || d_ready !== 1'b0) begin errors++; $display("FAIL rmid_busy: got rd=%b rdy=%b want 1 0", mem_read, d_ready); end
        rst = 1'b1; d_read = 1'b0;
        @(negedge clk);
        checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || d_ready !== 1'b0) begin errors++; $display("FAIL rmid_abort: got rd=%b wr=%b rdy=%b want 0 0 0", mem_read, mem_write, d_ready); end
        rst = 1'b0;
        log_q.delete();
        repeat (3) @(negedge clk);
        checks++; if (log_q.size() != 0 || mem_read !== 1'b0) begin errors++; $display("FAIL rmid_quiet: got %0d pulses rd=%b want 0 0", log_q.size(), mem_read); end
        lat = 2;
        i_addr = 28'h50; i_read = 1'b1;
        @(negedge clk);
        checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 28'h50) begin errors++; $display("FAIL rmid_regrant: got rd=%b wr=%b addr=%h want 1 0 050", mem_read, mem_write, mem_addr); end
        wait_ready(1'b0, n);
        checks++; if (n != 2 || i_rdata !== mem_content(28'h50)) begin errors++; $display("FAIL rmid_i_done: got n=%0d data=%h want 2 %h", n, i_rdata, mem_content(28'h50)); end
        i_read = 1'b0;
        @(negedge clk);
    endtask

`ifdef MEM_ARBITER_PERF_CNT_EN
    task automatic test_perf();
        int n;
        do_reset();
        lat = 3;
        d_addr = 28'h300; i_addr = 28'h310; d_read = 1'b1; i_read = 1'b1;
        wait_ready(1'b1, n); d_read = 1'b0;
        wait_ready(1'b0, n); i_read = 1'b0;
        @(negedge clk);
        checks++; if (i_wait_cnt !== 32'd5) begin errors++; $display("FAIL perf_i_wait: got %0d want 5", i_wait_cnt); end
        checks++; if (d_wait_cnt !== 32'd0) begin errors++; $display("FAIL perf_d_wait: got %0d want 0", d_wait_cnt); end
        force dut.u_i_wait.cnt = 32'hFFFF_FFFE;
        #1 release dut.u_i_wait.cnt;
        d_read = 1'b1;
        @(negedge clk);
        i_read = 1'b1;
        wait_ready(1'b1, n); d_read = 1'b0;
        wait_ready(1'b0, n); i_read = 1'b0;
        @(negedge clk);
        checks++; if (i_wait_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL perf_saturate: got %h want ffffffff", i_wait_cnt); end
    endtask
`endif

    task automatic test_random();
        int phase = 0, served = 0, stall = 0, cyc = 0;
        bit who = 1'b0, last_d = 1'b0, pi = 1'b0, pd = 1'b0, pw = 1'b0, g_wr = 1'b0, stop = 1'b0;
        logic [AW-1:0] pia = '0, pda = '0, g_addr = '0;
        logic [DW-1:0] pwd = '0, g_wd = '0;
        do_reset();
        rand_lat = 1'b1;
        lat = $urandom_range(1, 4);
        do begin
            @(negedge clk);
            cyc++;
            stop = cyc >= 500;
            if (phase == 0 && (pi || pd)) begin
                who = (pi && pd) ? !last_d : pd;
                g_wr = who && pw; g_addr = who ? pda : pia; g_wd = pwd;
                last_d = who; phase = 1; stall = 0;
                checks++;
                if (mem_read !== !g_wr || mem_write !== g_wr || mem_addr !== g_addr || (g_wr && mem_wdata !== g_wd)) begin
                    errors++; $display("FAIL rand_grant: got rd=%b wr=%b addr=%h want rd=%b wr=%b addr=%h winner=%0d", mem_read, mem_write, mem_addr, !g_wr, g_wr, g_addr, who);
                end
            end else if (phase == 1) begin
                checks++;
                if (i_ready || d_ready) begin
                    if ((who ? d_ready : i_ready) !== 1'b1 || (who ? i_ready : d_ready) !== 1'b0 ||
                        (!g_wr && (who ? d_rdata : i_rdata) !== mem_content(g_addr))) begin
                        errors++; $display("FAIL rand_complete: got irdy=%b drdy=%b winner=%0d addr=%h", i_ready, d_ready, who, g_addr);
                    end
                    phase = 2; served++;
                end else begin
                    stall++;
                    if (mem_addr !== g_addr || mem_read !== !g_wr || mem_write !== g_wr || stall > 8) begin
                        errors++; $display("FAIL rand_hold: got rd=%b wr=%b addr=%h stall=%0d want addr=%h", mem_read, mem_write, mem_addr, stall, g_addr);
                    end
                end
            end else begin
                checks++;
                if (mem_read || mem_write || i_ready || d_ready) begin
                    errors++; $display("FAIL rand_idle: got rd=%b wr=%b irdy=%b drdy=%b want all 0", mem_read, mem_write, i_ready, d_ready);
                end
                phase = 0;
            end
            if (i_ready) i_read = 1'b0;
            if (d_ready) begin d_read = 1'b0; d_write = 1'b0; end
            if (!stop && !i_read && $urandom_range(0, 2) == 0) begin
                i_read = 1'b1; i_addr = AW'($urandom_range(0, 15));
            end
            if (!stop && !d_read && !d_write && $urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 1) d_write = 1'b1; else d_read = 1'b1;
                d_addr = AW'($urandom_range(0, 15)); d_wdata = {4{$urandom}};
            end
            pi = i_read; pd = d_read || d_write; pw = d_write; pia = i_addr; pda = d_addr; pwd = d_wdata;
        end while (!(stop && phase == 0 && !pi && !pd) && cyc < 1000);
        checks++; if (cyc >= 1000 || served < 20) begin errors++; $display("FAIL rand_progress: got %0d served in %0d cycles want >=20 and drain", served, cyc); end
        rand_lat = 1'b0;
        lat = 3;
    endtask

    initial begin
        test_reset();
        test_i_only();
        test_d_write();
        test_simultaneous();
        test_fairness();
        test_reset_mid();
`ifdef MEM_ARBITER_PERF_CNT_EN
        test_perf();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
